uart_aes_ctrl: RTL
==================

Name: uart_aes_ctrl

Overview:
Command sequencer between the UART byte interface and the AES core in the CPA capture FPGA. It parses host commands from the UART receiver and loads a 128-bit key or plaintext. For an encrypt command it fires one AES operation, then streams the 16-byte ciphertext back through the UART transmitter. It drives the UART's level-sensitive transmit handshake so that each byte is sent exactly once.

Parameters:
TIMEOUT_CYCLES, 2000000, maximum clk cycles allowed between consecutive payload bytes before the frame is aborted (20 ms at 100 MHz).
ACK_BYTE, 8'h06, byte returned after a successful key load.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
rx_byte  in  8  byte from UART receiver
received  in  1  one-cycle pulse when rx_byte is valid
recv_error  in  1  one-cycle pulse on UART framing error
transmit  out  1  level request to UART transmitter
tx_byte  out  8  byte to UART transmitter, stable while transmit=1
is_transmitting  in  1  UART transmitter busy
key  out  128  AES key register
plaintext  out  128  AES plaintext register
aes_start  out  1  one-cycle start pulse to AES core
aes_done  in  1  one-cycle pulse, ciphertext valid
ciphertext  in  128  AES result, sampled on aes_done
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on protocol error or timeout

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; transmit=0, tx_byte=0, key=0, plaintext=0, aes_start=0, err=0, byte counter=0, timeout counter=0. Reset wins over every other event, mid-frame included.
- Commands, one byte, in IDLE: 8'h4B 'K' = key load, 8'h50 'P' = encrypt. Any other byte: err pulse, stay IDLE.
- Byte order: first payload byte goes to bits [127:120], 16th to [7:0], by shifting left 8 per byte. Ciphertext is returned MSB byte ([127:120]) first.
- States:
  - IDLE: on received, decode command. 'K' -> RX_KEY, 'P' -> RX_PT. Clear the byte counter and timeout counter.
  - RX_KEY / RX_PT: on each received, shift the byte into key/plaintext and increment cnt (4-bit). When the 16th byte arrives (cnt==15 with received): RX_KEY -> TX_LOAD with tx_byte=ACK_BYTE and a 1-byte send count; RX_PT -> AES_START.
  - AES_START: aes_start=1 for exactly one cycle -> AES_WAIT.
  - AES_WAIT: on aes_done, latch ciphertext into a 128-bit shift register and set the send count to 16 -> TX_LOAD. There is no timeout in this state.
  - TX_LOAD: drive tx_byte (ack or shift[127:120]) and set transmit=1 -> TX_WAIT_BUSY.
  - TX_WAIT_BUSY: hold transmit=1 until is_transmitting=1, then transmit=0 -> TX_WAIT_DONE.
  - TX_WAIT_DONE: wait for is_transmitting=0. Then shift left 8 and decrement the send count. If the count reaches 0 -> IDLE, else -> TX_LOAD.
- Timeout: in RX_KEY/RX_PT the counter increments every cycle and clears on received. When it reaches TIMEOUT_CYCLES-1: err pulse -> IDLE. Partially loaded register contents are left as-is and are not used.
- recv_error in any RX state: err pulse -> IDLE. In IDLE: ignored, no err.
- received while in AES_START/AES_WAIT/TX_* is dropped silently.
- aes_done outside AES_WAIT is ignored.
- key is unchanged by 'P' frames. plaintext is unchanged by 'K' frames.
- transmit is never high for two separate bytes without an intervening is_transmitting 1->0 cycle.

Test Plan:
- Reset mid-RX_PT after 5 bytes -> next cycle busy=0, plaintext=0, transmit=0. A following full 'P' frame behaves normally.
- Send 'K' + bytes 00..0F -> key=128'h000102..0F, one tx byte 0x06, busy returns 0, aes_start never asserted.
- Send 'P' + bytes 00,11..FF (16 bytes); stub AES returns ciphertext=plaintext^key 5 cycles after aes_start -> exactly one aes_start pulse; 16 tx bytes in MSB-first order matching the expected value.
- Send 0x41 -> single err pulse, busy stays 0, no tx. Then 'P' + 3 bytes and stall > TIMEOUT_CYCLES (bench overrides it to 100) -> err pulse at gap cycle 100, state IDLE.
- recv_error pulse after 'K' + 7 bytes -> err pulse, IDLE. A subsequent full 'K' frame loads the correct key.
- UART model holds is_transmitting high for 50 cycles per byte and keeps TX_RECOVER semantics -> each of the 16 bytes is transmitted exactly once and none are duplicated; received bytes injected during TX are ignored.

Source files
------------

// File: rtl/uart_aes_ctrl.sv
// uart_aes_ctrl: host command sequencer between the UART byte interface and
// the AES core. 'K' + 16 bytes loads the key and returns an ACK byte,
// 'P' + 16 bytes loads the plaintext, runs one encryption and returns the
// 16-byte ciphertext MSB byte first through a level-sensitive TX handshake.
module uart_aes_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_byte,
  input  logic         received,
  input  logic         recv_error,
  output logic         transmit,
  output logic [7:0]   tx_byte,
  input  logic         is_transmitting,
  output logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] ciphertext,
  output logic         busy,
  output logic         err
);

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h50;
  localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_KEY,
    S_RX_PT,
    S_AES_START,
    S_AES_WAIT,
    S_TX_LOAD,
    S_TX_WAIT_BUSY,
    S_TX_WAIT_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   shift_q, shift_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [4:0]     send_q, send_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           transmit_q, transmit_d;
  logic           err_q, err_d;

  // Next-state and datapath update for the command sequencer
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    pt_d       = pt_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    send_d     = send_q;
    tmo_d      = tmo_q;
    tx_byte_d  = tx_byte_q;
    transmit_d = transmit_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // recv_error is deliberately ignored here: no frame is in progress
        if (received) begin
          cnt_d = 4'd0;
          tmo_d = '0;
          if (rx_byte == CMD_KEY) begin
            state_d = S_RX_KEY;
          end else if (rx_byte == CMD_ENC) begin
            state_d = S_RX_PT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RX_KEY, S_RX_PT: begin
        if (recv_error) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (received) begin
          tmo_d = '0;
          cnt_d = cnt_q + 4'd1;
          if (state_q == S_RX_KEY) begin
            key_d = {key_q[119:0], rx_byte};
          end else begin
            pt_d = {pt_q[119:0], rx_byte};
          end
          if (cnt_q == 4'd15) begin
            if (state_q == S_RX_KEY) begin
              // The ACK travels through the same shift path as ciphertext
              shift_d = {ACK_BYTE, 120'd0};
              send_d  = 5'd1;
              state_d = S_TX_LOAD;
            end else begin
              state_d = S_AES_START;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abandon the frame; the partially shifted register is not used
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_AES_START: begin
        state_d = S_AES_WAIT;
      end

      S_AES_WAIT: begin
        if (aes_done) begin
          shift_d = ciphertext;
          send_d  = 5'd16;
          state_d = S_TX_LOAD;
        end
      end

      S_TX_LOAD: begin
        tx_byte_d  = shift_q[127:120];
        transmit_d = 1'b1;
        state_d    = S_TX_WAIT_BUSY;
      end

      S_TX_WAIT_BUSY: begin
        // Drop the request as soon as the UART accepts it so it is sent once
        if (is_transmitting) begin
          transmit_d = 1'b0;
          state_d    = S_TX_WAIT_DONE;
        end
      end

      S_TX_WAIT_DONE: begin
        if (!is_transmitting) begin
          shift_d = {shift_q[119:0], 8'd0};
          send_d  = send_q - 5'd1;
          state_d = (send_q == 5'd1) ? S_IDLE : S_TX_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      pt_q       <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      send_q     <= '0;
      tmo_q      <= '0;
      tx_byte_q  <= '0;
      transmit_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      send_q     <= send_d;
      tmo_q      <= tmo_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
      err_q      <= err_d;
    end
  end

  assign transmit  = transmit_q;
  assign tx_byte   = tx_byte_q;
  assign key       = key_q;
  assign plaintext = pt_q;
  assign aes_start = (state_q == S_AES_START);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule
